// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants: bus widths, bubble encoding, reset vector and FSM encodings.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord         = 32'h0000_0000;
  localparam logic [InstBus-1:0]     NopInst          = ZeroWord;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] IfIdle = 2'd0;
  localparam logic [1:0] IfReq  = 2'd1;
  localparam logic [1:0] IfHold = 2'd2;
  localparam logic [1:0] IfDrop = 2'd3;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_slot_t;

  function automatic if_slot_t make_slot(input logic [InstAddrBus-1:0] pc,
                                         input logic [InstBus-1:0] inst);
    if_slot_t s;
    s.pc   = pc;
    s.inst = inst;
    return s;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with next-pc selection: reset vector, redirect, +4 advance, or hold.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [InstAddrBus-1:0] i_target,
  input  logic                   i_advance,
  output logic [InstAddrBus-1:0] o_pc
);

  logic [InstAddrBus-1:0] r_pc;
  logic [InstAddrBus-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_target;
    end else if (i_advance) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding memory reads, one-entry skid for downstream stall,
// and a DROP state that swallows the in-flight response after a redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   inst_req,
  output logic [InstAddrBus-1:0] inst_addr,
  input  logic                   inst_rvalid,
  input  logic [InstBus-1:0]     inst_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst
);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  if_slot_t               r_slot;
  if_slot_t               w_slot_nxt;
  if_slot_t               r_skid;
  if_slot_t               w_skid_nxt;
  logic [InstAddrBus-1:0] w_pc;
  logic [InstAddrBus-1:0] w_target;
  logic                   w_advance;

  assign w_target  = branch_target_i & 32'hFFFF_FFFC;
  assign w_advance = !branch_flag_i && (r_state == IfReq) && inst_rvalid;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .i_rst      (rst),
    .i_redirect (branch_flag_i),
    .i_target   (w_target),
    .i_advance  (w_advance),
    .o_pc       (w_pc)
  );

  // Redirect outranks everything; a pending request without data must still be drained in DROP.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_skid_nxt  = r_skid;
    if (branch_flag_i) begin
      w_slot_nxt = make_slot(w_target, NopInst);
      w_skid_nxt = '0;
      case (r_state)
        IfReq:   w_state_nxt = inst_rvalid ? IfReq : IfDrop;
        IfDrop:  w_state_nxt = IfDrop;
        default: w_state_nxt = IfReq;
      endcase
    end else begin
      case (r_state)
        IfIdle: w_state_nxt = IfReq;
        IfReq: begin
          if (inst_rvalid) begin
            if (stall) begin
              w_skid_nxt  = make_slot(w_pc, inst_rdata);
              w_state_nxt = IfHold;
            end else begin
              w_slot_nxt = make_slot(w_pc, inst_rdata);
            end
          end else if (!stall) begin
            w_slot_nxt = make_slot(w_pc, NopInst);
          end
        end
        IfHold: begin
          if (!stall) begin
            w_slot_nxt  = r_skid;
            w_skid_nxt  = '0;
            w_state_nxt = IfReq;
          end
        end
        IfDrop: begin
          if (!stall) begin
            w_slot_nxt = make_slot(w_pc, NopInst);
          end
          if (inst_rvalid) begin
            w_state_nxt = IfReq;
          end
        end
        default: w_state_nxt = IfIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IfIdle;
      r_slot  <= make_slot(ZeroWord, ZeroWord);
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign inst_req  = (r_state == IfReq) || (r_state == IfDrop);
  assign inst_addr = w_pc;
  assign if_pc     = r_slot.pc;
  assign if_inst   = r_slot.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: latency-programmable memory model, stall, redirects, pc wrap and reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic        rst2;
  logic        inst_req2;
  logic [31:0] inst_addr2;
  logic        inst_rvalid2;
  logic [31:0] inst_rdata2;
  logic [31:0] if_pc2;
  logic [31:0] if_inst2;
  logic        mem2_en;

  int n_vec  = 0;
  int n_miss = 0;

  int          lat;
  logic        m_busy;
  logic [31:0] m_addr;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_rvalid     (inst_rvalid),
    .inst_rdata      (inst_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk             (clk),
    .rst             (rst2),
    .stall           (1'b0),
    .branch_flag_i   (1'b0),
    .branch_target_i (32'h0),
    .inst_req        (inst_req2),
    .inst_addr       (inst_addr2),
    .inst_rvalid     (inst_rvalid2),
    .inst_rdata      (inst_rdata2),
    .if_pc           (if_pc2),
    .if_inst         (if_inst2)
  );

  // Memory answers lat cycles after first sight of a request; the address is latched at that point.
  always_comb begin
    if (m_busy) begin
      inst_rvalid = inst_req && (m_cnt >= lat - 1);
      inst_rdata  = mem_word(m_addr);
    end else begin
      inst_rvalid = inst_req && (lat == 1);
      inst_rdata  = mem_word(inst_addr);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 32'h0;
    end else if (inst_rvalid) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (inst_req) begin
      if (!m_busy) begin
        m_busy <= 1'b1;
        m_addr <= inst_addr;
        m_cnt  <= 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign inst_rvalid2 = inst_req2 && mem2_en;
  assign inst_rdata2  = mem_word(inst_addr2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".inst"}, if_inst, inst);
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'h0, inst_req}, {31'h0, req});
    chk({tag, ".addr"}, inst_addr, addr);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; mem2_en = 1'b0;
    stall = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0; lat = 1;
    tick(); tick();
    chk_slot("rst", 32'h0, 32'h0);
    chk_mem("rst", 1'b0, 32'h0);

    // back-to-back with single-cycle memory
    rst = 1'b0;
    tick();
    chk_slot("idle_exit", 32'h0, 32'h0);
    chk_mem("idle_exit", 1'b1, 32'h0);
    tick(); chk_slot("b2b0", 32'h0, mem_word(32'h0));  chk_mem("b2b0", 1'b1, 32'h4);
    tick(); chk_slot("b2b4", 32'h4, mem_word(32'h4));  chk_mem("b2b4", 1'b1, 32'h8);
    tick(); chk_slot("b2b8", 32'h8, mem_word(32'h8));  chk_mem("b2b8", 1'b1, 32'hC);
    tick(); chk_slot("b2bC", 32'hC, mem_word(32'hC));  chk_mem("b2bC", 1'b1, 32'h10);

    // three-cycle latency: two bubbles, address held
    lat = 3;
    tick(); chk_slot("lat3_b1", 32'h10, 32'h0); chk_mem("lat3_b1", 1'b1, 32'h10);
    tick(); chk_slot("lat3_b2", 32'h10, 32'h0); chk_mem("lat3_b2", 1'b1, 32'h10);
    tick(); chk_slot("lat3_d", 32'h10, mem_word(32'h10)); chk_mem("lat3_d", 1'b1, 32'h14);

    // stall as data arrives: skid and HOLD for four cycles
    lat = 1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_slot("hold", 32'h10, mem_word(32'h10));
      chk_mem("hold", 1'b0, 32'h18);
    end
    stall = 1'b0;
    tick(); chk_slot("unskid", 32'h14, mem_word(32'h14)); chk_mem("unskid", 1'b1, 32'h18);
    tick(); chk_slot("post_skid", 32'h18, mem_word(32'h18)); chk_mem("post_skid", 1'b1, 32'h1C);

    // redirect with request outstanding -> DROP, stale data discarded
    lat = 3;
    tick(); chk_slot("pre_drop", 32'h1C, 32'h0);
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0103;
    tick(); branch_flag_i = 1'b0;
    chk_slot("redir", 32'h100, 32'h0); chk_mem("redir", 1'b1, 32'h100);
    tick(); chk_slot("drop_done", 32'h100, 32'h0); chk_mem("drop_done", 1'b1, 32'h100);
    tick(); chk_slot("tgt_b1", 32'h100, 32'h0);
    tick(); chk_slot("tgt_b2", 32'h100, 32'h0);
    tick(); chk_slot("tgt_d", 32'h100, mem_word(32'h100)); chk_mem("tgt_d", 1'b1, 32'h104);

    // redirect coincident with rvalid
    lat = 1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick(); branch_flag_i = 1'b0;
    chk_slot("redir_rv", 32'h200, 32'h0); chk_mem("redir_rv", 1'b1, 32'h200);
    tick(); chk_slot("redir_rv_d", 32'h200, mem_word(32'h200));

    // redirect while in HOLD, stall still high
    stall = 1'b1;
    tick(); chk_mem("hold2", 1'b0, 32'h208);
    branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick(); branch_flag_i = 1'b0; stall = 1'b0;
    chk_slot("redir_hold", 32'h300, 32'h0); chk_mem("redir_hold", 1'b1, 32'h300);
    tick(); chk_slot("redir_hold_d", 32'h300, mem_word(32'h300));

    // redirect while already in DROP: one stale response still awaited
    lat = 4;
    tick(); chk_slot("pre_drop2", 32'h304, 32'h0);
    branch_flag_i = 1'b1; branch_target_i = 32'h400;
    tick(); branch_target_i = 32'h500;
    tick(); branch_flag_i = 1'b0;
    chk_slot("redir_drop", 32'h500, 32'h0); chk_mem("redir_drop", 1'b1, 32'h500);
    lat = 1;
    tick(); chk_slot("drop2_done", 32'h500, 32'h0);
    tick(); chk_slot("drop2_d", 32'h500, mem_word(32'h500));

    // second instance: pc wrap and reset mid-request
    tick();
    chk("w_rst.pc", if_pc2, 32'h0);
    chk("w_rst.addr", inst_addr2, 32'hFFFF_FFF8);
    rst2 = 1'b0; mem2_en = 1'b1;
    tick(); chk("w_idle.req", {31'h0, inst_req2}, 32'h1);
    tick(); chk("w0.pc", if_pc2, 32'hFFFF_FFF8); chk("w0.inst", if_inst2, mem_word(32'hFFFF_FFF8));
    tick(); chk("w1.pc", if_pc2, 32'hFFFF_FFFC); chk("w1.inst", if_inst2, mem_word(32'hFFFF_FFFC));
    tick(); chk("w2.pc", if_pc2, 32'h0); chk("w2.inst", if_inst2, mem_word(32'h0));
    chk("w2.addr", inst_addr2, 32'h4);
    mem2_en = 1'b0;
    tick(); chk("w_wait.inst", if_inst2, 32'h0);
    rst2 = 1'b1;
    tick();
    chk("mid_rst.pc", if_pc2, 32'h0);
    chk("mid_rst.inst", if_inst2, 32'h0);
    chk("mid_rst.req", {31'h0, inst_req2}, 32'h0);
    chk("mid_rst.addr", inst_addr2, 32'hFFFF_FFF8);
    rst2 = 1'b0; mem2_en = 1'b1;
    tick();
    tick(); chk("restart.pc", if_pc2, 32'hFFFF_FFF8); chk("restart.inst", if_inst2, mem_word(32'hFFFF_FFF8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
